// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-NCH dispatcher.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 16;
  localparam int unsigned DEMUX_NCH   = 16;
  localparam int unsigned DEMUX_SEL_W = 5;
  localparam int unsigned DROP_CNT_W  = 8;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/demux_dispatch_if.sv
// Valid/ready bundle between the decode stage (master) and the dispatcher (slave).
interface demux_dispatch_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned NCH   = DEMUX_NCH,
  parameter int unsigned SEL_W = DEMUX_SEL_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SEL_W-1:0]     fn_sel;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, fn_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, fn_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_slot.sv
// One-deep holding register: a load wins over a same-cycle drain, data holds when empty.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_dispatch.sv
// Registered 1-to-NCH dispatcher with per-channel back-pressure and sticky
// out-of-range select reporting.
module demux_dispatch
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned NCH   = DEMUX_NCH,
  parameter int unsigned SEL_W = DEMUX_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_dispatch_if.slave       bus,
  input  logic                  err_clr,
  output logic                  err,
  output logic [SEL_W-1:0]      err_sel,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [31:0]          sel_ext;
  logic                 in_range;
  logic [NCH-1:0]       sel_oh;
  logic                 in_ready;
  logic                 accept;
  logic                 drop;
  logic [NCH-1:0]       load;
  logic [NCH-1:0]       slot_valid;
  logic [WIDTH-1:0]     slot_data [NCH];
  logic [NCH*WIDTH-1:0] out_data_flat;

  assign sel_ext  = 32'(bus.fn_sel);
  assign in_range = sel_ext < NCH;

  always_comb begin
    sel_oh = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      sel_oh[k] = (sel_ext == k);
    end
  end

  // Out-of-range selects are always accepted so the drop can be counted.
  assign in_ready = !in_range || |(sel_oh & (~slot_valid | bus.out_ready));
  assign accept   = bus.in_valid && in_ready;
  assign drop     = accept && !in_range;
  assign load     = {NCH{accept}} & sel_oh;

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[g]),
      .data_i  (bus.in_data),
      .ready_i (bus.out_ready[g]),
      .valid_o (slot_valid[g]),
      .data_o  (slot_data[g])
    );
  end

  always_comb begin
    out_data_flat = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      out_data_flat[k*WIDTH +: WIDTH] = slot_data[k];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = slot_valid;
  assign bus.out_data  = out_data_flat;

  logic                  err_q, err_d;
  logic [SEL_W-1:0]      err_sel_q, err_sel_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Clear beats a same-cycle drop; err_sel keeps only the first offender.
  always_comb begin
    err_d      = err_q;
    err_sel_d  = err_sel_q;
    drop_cnt_d = drop_cnt_q;
    if (err_clr) begin
      err_d      = 1'b0;
      err_sel_d  = '0;
      drop_cnt_d = '0;
    end else if (drop) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_sel_d = bus.fn_sel;
      end
      if (drop_cnt_q != DROP_CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_sel_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      err_sel_q  <= err_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err      = err_q;
  assign err_sel  = err_sel_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_dispatch.sv
// Bench for demux_dispatch: directed scenarios plus random traffic against a slot-array model.
module tb_demux_dispatch;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NCH   = 16;
  localparam int unsigned SEL_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             err_clr;
  logic             err;
  logic [SEL_W-1:0] err_sel;
  logic [7:0]       drop_cnt;

  demux_dispatch_if #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)) bus ();

  demux_dispatch #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_clr  (err_clr),
    .err      (err),
    .err_sel  (err_sel),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model: one slot per channel plus the error fields.
  bit               m_valid [NCH];
  logic [WIDTH-1:0] m_data  [NCH];
  bit               m_err;
  int               m_err_sel;
  int               m_drop;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    int sel;
    sel = int'(bus.fn_sel);
    if (sel >= int'(NCH)) return 1'b1;
    return !m_valid[sel] || bus.out_ready[sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    int sel;
    if (!rst_n) begin
      for (int k = 0; k < int'(NCH); k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
      end
      m_err = 1'b0; m_err_sel = 0; m_drop = 0;
    end else begin
      rdy = model_ready();
      sel = int'(bus.fn_sel);
      for (int k = 0; k < int'(NCH); k++)
        if (m_valid[k] && bus.out_ready[k]) m_valid[k] = 1'b0;
      if (bus.in_valid && rdy) begin
        if (sel < int'(NCH)) begin
          m_valid[sel] = 1'b1;
          m_data[sel]  = bus.in_data;
        end else if (!err_clr) begin
          if (!m_err) m_err_sel = sel;
          m_err = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (err_clr) begin
        m_err = 1'b0; m_err_sel = 0; m_drop = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0]       ev;
    logic [NCH*WIDTH-1:0] ed;
    if (rst_n && cmp_en) begin
      for (int k = 0; k < int'(NCH); k++) begin
        ev[k] = m_valid[k];
        ed[k*WIDTH +: WIDTH] = m_data[k];
      end
      chk("in_ready", 256'(bus.in_ready), 256'(model_ready()));
      chk("out_valid", 256'(bus.out_valid), 256'(ev));
      chk("out_data", 256'(bus.out_data), 256'(ed));
      chk("err", 256'(err), 256'(m_err));
      chk("err_sel", 256'(err_sel), 256'(m_err_sel));
      chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
    end
  end

  task automatic setin(input bit v, input int sel, input logic [WIDTH-1:0] d,
                       input logic [NCH-1:0] ordy, input bit clr);
    bus.in_valid  = v;
    bus.fn_sel    = sel[SEL_W-1:0];
    bus.in_data   = d;
    bus.out_ready = ordy;
    err_clr       = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int sel, input logic [WIDTH-1:0] d,
                       input logic [NCH-1:0] ordy, input bit clr);
    setin(v, sel, d, ordy, clr);
    tick();
  endtask

  initial begin
    setin(1'b0, 0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset then idle
    tick();
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_data", 256'(bus.out_data), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_err_sel", 256'(err_sel), 256'(0));
    chk("rst_drop_cnt", 256'(drop_cnt), 256'(0));

    // Channel 5 load and back-pressure
    drive(1'b1, 5, 16'hA5A5, '0, 1'b0);
    chk("ch5_valid", 256'(bus.out_valid), 256'(16'h0020));
    chk("ch5_data", 256'(bus.out_data[95:80]), 256'(16'hA5A5));
    setin(1'b1, 5, 16'h1111, '0, 1'b0);
    #1 chk("ch5_blocked", 256'(bus.in_ready), 256'(0));
    tick();
    chk("ch5_held", 256'(bus.out_data[95:80]), 256'(16'hA5A5));
    setin(1'b1, 5, 16'h1111, 16'h0020, 1'b0);
    #1 chk("ch5_unblocked", 256'(bus.in_ready), 256'(1));
    tick();
    chk("ch5_reload_valid", 256'(bus.out_valid), 256'(16'h0020));
    chk("ch5_reload_data", 256'(bus.out_data[95:80]), 256'(16'h1111));
    drive(1'b0, 0, '0, '1, 1'b0);
    chk("ch5_drained", 256'(bus.out_valid), 256'(0));

    // Channel 2 simultaneous drain/load and back-to-back stream
    drive(1'b1, 2, 16'h0000, '0, 1'b0);
    setin(1'b1, 2, 16'h1234, 16'h0004, 1'b0);
    #1 chk("ch2_ready", 256'(bus.in_ready), 256'(1));
    tick();
    chk("ch2_valid", 256'(bus.out_valid), 256'(16'h0004));
    chk("ch2_data", 256'(bus.out_data[47:32]), 256'(16'h1234));
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2, WIDTH'(i), 16'h0004, 1'b0);
      chk("ch2_stream", 256'(bus.out_data[47:32]), 256'(i));
    end
    drive(1'b0, 0, '0, '1, 1'b0);

    // All sixteen channels full, then a single drain-all cycle
    for (int i = 0; i < 16; i++) drive(1'b1, i, WIDTH'(16'h100 + i), '0, 1'b0);
    chk("all_full", 256'(bus.out_valid), 256'(16'hFFFF));
    chk("ch9_data", 256'(bus.out_data[159:144]), 256'(16'h0109));
    drive(1'b0, 0, '0, '1, 1'b0);
    chk("all_drained", 256'(bus.out_valid), 256'(0));
    chk("ch7_holds", 256'(bus.out_data[127:112]), 256'(16'h0107));

    // Out-of-range selects
    setin(1'b1, 17, 16'hDEAD, '0, 1'b0);
    #1 chk("oor_ready", 256'(bus.in_ready), 256'(1));
    tick();
    drive(1'b1, 20, 16'hBEEF, '0, 1'b0);
    chk("oor_no_slot", 256'(bus.out_valid), 256'(0));
    chk("oor_err", 256'(err), 256'(1));
    chk("oor_err_sel", 256'(err_sel), 256'(17));
    chk("oor_drop2", 256'(drop_cnt), 256'(2));
    repeat (298) drive(1'b1, 16 + int'($urandom_range(0, 15)), 16'h0, '0, 1'b0);
    chk("drop_sat", 256'(drop_cnt), 256'(255));
    chk("model_drop_sat", 256'(m_drop), 256'(255));
    drive(1'b1, 25, 16'h0, '0, 1'b1);
    chk("clr_err", 256'(err), 256'(0));
    chk("clr_err_sel", 256'(err_sel), 256'(0));
    chk("clr_drop", 256'(drop_cnt), 256'(0));
    drive(1'b1, 31, 16'h0, '0, 1'b0);
    chk("err_sel_after_clr", 256'(err_sel), 256'(31));
    chk("drop_after_clr", 256'(drop_cnt), 256'(1));
    drive(1'b0, 0, '0, '0, 1'b1);

    // Asynchronous reset with slot 3 occupied
    drive(1'b1, 3, 16'h3333, '0, 1'b0);
    chk("ch3_full", 256'(bus.out_valid), 256'(16'h0008));
    setin(1'b0, 0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 256'(bus.out_valid), 256'(0));
    chk("async_rst_data", 256'(bus.out_data), 256'(0));
    tick();
    rst_n = 1'b1;

    // Random traffic checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31))
                                          : int'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, sel, WIDTH'($urandom), NCH'($urandom),
            $urandom_range(0, 31) == 0);
    end

    drive(1'b0, 0, '0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
